// File: rtl/shift_issue_arbiter_pkg.sv
// Shared types and the shift helper for the shared-shifter issue path.
// Latency: n/a (types and pure function only).
// Backpressure: n/a.
package Shift_pkg;

   localparam logic [4:0] SHIFT_MASK = 5'h1F;
   // Upper bounds on destination and tag widths (ADDR_W <= 8, NUM_REQ <= 8)
   localparam int DEST_W_MAX = 8;
   localparam int TAG_W_MAX  = 3;

   typedef struct packed {
      logic [31:0]           a;
      logic [4:0]            b;
      logic [DEST_W_MAX-1:0] dest;
      logic                  left;
      logic                  exec;
   } shift_req_t;

   typedef struct packed {
      logic                  we;
      logic [DEST_W_MAX-1:0] dest;
      logic [31:0]           data;
      logic [TAG_W_MAX-1:0]  tag;
   } shift_wb_t;

   function automatic logic [31:0] shift_result(input logic [31:0] a,
                                                input logic [4:0]  b,
                                                input logic        left);
      logic [4:0] amt;
      amt = b & SHIFT_MASK;
      return left ? (a << amt) : (a >> amt);
   endfunction

endpackage

// File: rtl/shift_issue_arbiter_rr.sv
// Round-robin grant over N requesters, pointer moves past the winner on advance.
// Latency: grant is combinational; pointer updates on the advancing edge.
// Backpressure: pointer holds whenever advance is low.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

   logic [IDX_W-1:0] rr_ptr;

   always_comb begin
      logic [IDX_W-1:0] lane;
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      lane      = '0;
      for (int k = 0; k < N; k++) begin
         lane = IDX_W'((int'(rr_ptr) + k) % N);
         if (!any_req && req[lane]) begin
            any_req     = 1'b1;
            grant[lane] = 1'b1;
            grant_idx   = lane;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/shift_issue_arbiter.sv
// Arbitrates NUM_REQ lanes onto one two-stage logical shifter with tagged write-back.
// Latency: accepted at edge N, wb_valid after edge N+1; one op/cycle when wb_ready.
// Backpressure: wb_ready low holds stage 2, stage 1 fills, then req_ready drops.
module shift_issue_arbiter
   import Shift_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int ADDR_W  = 5,
   localparam int TAG_W   = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0][31:0]       req_a,
   input  logic [NUM_REQ-1:0][31:0]       req_b,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_dest,
   input  logic [NUM_REQ-1:0]             req_left,
   input  logic [NUM_REQ-1:0]             req_exec,
   output logic                           wb_valid,
   input  logic                           wb_ready,
   output logic                           wb_we,
   output logic [ADDR_W-1:0]              wb_dest,
   output logic [31:0]                    wb_data,
   output logic [TAG_W-1:0]               wb_tag,
   output logic                           busy
);

   logic [NUM_REQ-1:0] grant;
   logic [TAG_W-1:0]   grant_idx;
   logic               any_req;
   logic               s1_vld, s2_vld;
   logic               s1_accept, s2_accept, xfer;
   shift_req_t         cap_req, s1_req;
   logic [TAG_W-1:0]   s1_tag;
   shift_wb_t          s2_wb;
   logic               unused_bits;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign s2_accept = !s2_vld || wb_ready;
   assign s1_accept = !s1_vld || s2_accept;
   // rst_n gates the handshake so req_ready reads 0 while reset is held
   assign xfer      = any_req && s1_accept && rst_n;
   assign req_ready = grant & {NUM_REQ{s1_accept && rst_n}};

   always_comb begin
      cap_req      = '0;
      cap_req.a    = req_a[grant_idx];
      cap_req.b    = req_b[grant_idx][4:0] & SHIFT_MASK;
      cap_req.dest = DEST_W_MAX'(req_dest[grant_idx]);
      cap_req.left = req_left[grant_idx];
      cap_req.exec = req_exec[grant_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_req <= '0;
         s1_tag <= '0;
      end else if (s1_accept) begin
         s1_vld <= xfer;
         if (xfer) begin
            s1_req <= cap_req;
            s1_tag <= grant_idx;
         end
      end
   end

   // Result is computed on the stage 1 -> 2 move, regardless of exec
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld <= 1'b0;
         s2_wb  <= '0;
      end else if (s2_accept) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_wb.we   <= s1_req.exec;
            s2_wb.dest <= s1_req.dest;
            s2_wb.data <= shift_result(s1_req.a, s1_req.b, s1_req.left);
            s2_wb.tag  <= TAG_W_MAX'(s1_tag);
         end
      end
   end

   assign wb_valid = s2_vld;
   assign wb_we    = s2_wb.we;
   assign wb_dest  = s2_wb.dest[ADDR_W-1:0];
   assign wb_data  = s2_wb.data;
   assign wb_tag   = s2_wb.tag[TAG_W-1:0];
   assign busy     = s1_vld || s2_vld;

   assign unused_bits = ^{req_b, s2_wb.dest, s2_wb.tag};

endmodule

// File: tb/tb_shift_issue_arbiter.sv
// Directed plus random stimulus against a queue-based reference of the shared shifter.
module tb_shift_issue_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          req_valid, req_ready, req_left, req_exec;
   logic [N-1:0][31:0]    req_a, req_b;
   logic [N-1:0][AW-1:0]  req_dest;
   logic                  wb_valid, wb_ready, wb_we, busy;
   logic [AW-1:0]         wb_dest;
   logic [31:0]           wb_data;
   logic [1:0]            wb_tag;

   always #5 clk = ~clk;

   shift_issue_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_dest  (req_dest),
      .req_left  (req_left),
      .req_exec  (req_exec),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_we     (wb_we),
      .wb_dest   (wb_dest),
      .wb_data   (wb_data),
      .wb_tag    (wb_tag),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0]   data;
      logic [AW-1:0] dest;
      logic          we;
      int            tag;
      int            acc;
   } exp_t;

   exp_t          q[$];
   int            ptr, cyc, total, bad, delivered;
   logic [N-1:0]  obs_ready;
   logic          obs_vld, obs_we;
   logic [31:0]   obs_data;
   logic [AW-1:0] obs_dest;
   logic [1:0]    obs_tag;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Logical shift as multiply/divide by a power of two, modulo 2^32
   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                             input logic left);
      logic [63:0] w, p;
      int n;
      n = int'(b % 32);
      p = 64'd1;
      repeat (n) p = p * 2;
      w = {32'b0, a};
      if (left) w = w * p;
      else      w = w / p;
      return w[31:0];
   endfunction

   // Checks one cycle at the falling edge, advances the model, returns just after the rising edge
   task automatic step();
      logic [N-1:0] er;
      logic         exp_vld;
      int           g, lane;
      exp_t         e;
      @(negedge clk);
      exp_vld = (q.size() > 0) && (q[0].acc < cyc);
      check("wb_valid", wb_valid, exp_vld);
      check("busy", busy, q.size() > 0);
      if (exp_vld) begin
         check("wb_data", wb_data, q[0].data);
         check("wb_dest", wb_dest, q[0].dest);
         check("wb_we", wb_we, q[0].we);
         check("wb_tag", wb_tag, 64'(q[0].tag));
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
         lane = (ptr + k) % N;
         if (g < 0 && req_valid[lane]) g = lane;
      end
      er = '0;
      if (g >= 0 && (q.size() < 2 || wb_ready)) er[g] = 1'b1;
      check("req_ready", req_ready, er);
      obs_ready = req_ready;
      obs_vld   = wb_valid;
      obs_we    = wb_we;
      obs_data  = wb_data;
      obs_dest  = wb_dest;
      obs_tag   = wb_tag;
      if (exp_vld && wb_ready) begin
         void'(q.pop_front());
         delivered++;
      end
      if (er != '0) begin
         e.data = ref_shift(req_a[g], req_b[g], req_left[g]);
         e.dest = req_dest[g];
         e.we   = req_exec[g];
         e.tag  = g;
         e.acc  = cyc + 1;
         q.push_back(e);
         ptr = (g + 1) % N;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [AW-1:0] d, input logic l, input logic x);
      req_valid[i] = 1'b1;
      req_a[i]     = a;
      req_b[i]     = b;
      req_dest[i]  = d;
      req_left[i]  = l;
      req_exec[i]  = x;
   endtask

   task automatic send_one(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [AW-1:0] d, input logic l, input logic x);
      set_lane(i, a, b, d, l, x);
      for (int n = 0; n < 10; n++) begin
         step();
         if (obs_ready[i]) break;
      end
      check("send_accept", obs_ready[i], 1);
      req_valid[i] = 1'b0;
      step();
      check("lat_not_yet", obs_vld, 0);
      step();
      check("lat_visible", obs_vld, 1);
   endtask

   initial begin
      int nacc, nsent, base;
      logic [31:0] bp_a[6];
      total = 0; bad = 0; cyc = 0; ptr = 0; delivered = 0;
      req_valid = '1; req_a = '1; req_b = '0; req_dest = '1;
      req_left = '0; req_exec = '1; wb_ready = 1'b1;

      // Reset state with requests pending
      #2;
      check("rst_req_ready", req_ready, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_wb_data", wb_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      req_valid = '0;

      // Fairness: all lanes continuously valid
      for (int i = 0; i < N; i++) set_lane(i, $urandom, $urandom, AW'(i), 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         step();
         check("fair_all", obs_ready, 4'b0001 << (k % 4));
      end
      req_valid = 4'b0010;
      step();
      check("fair_to_ptr2", obs_ready, 4'b0010);
      req_valid = 4'b1010;
      step();
      check("fair_ptr2_a", obs_ready, 4'b1000);
      step();
      check("fair_ptr2_b", obs_ready, 4'b0010);
      req_valid = '0;
      repeat (3) step();

      // Single op, modulo shift amounts, suppressed op
      send_one(0, 32'h0000_00F0, 32'd4, 5'd3, 1'b1, 1'b1);
      check("single_data", obs_data, 32'h0000_0F00);
      check("single_dest", obs_dest, 3);
      check("single_tag", obs_tag, 0);
      check("single_we", obs_we, 1);
      send_one(2, 32'h8000_0001, 32'd33, 5'd5, 1'b0, 1'b1);
      check("mod33_right", obs_data, 32'h4000_0000);
      send_one(1, 32'h8000_0001, 32'd32, 5'd6, 1'b1, 1'b1);
      check("mod32_left", obs_data, 32'h8000_0001);
      send_one(3, 32'hFFFF_FFFF, 32'd8, 5'd7, 1'b1, 1'b0);
      check("supp_we", obs_we, 0);
      check("supp_data", obs_data, 32'hFFFF_FF00);
      repeat (2) step();

      // Backpressure: 6-op stream on lane 0, write port blocked for 5 cycles
      foreach (bp_a[j]) bp_a[j] = $urandom;
      base = delivered;
      wb_ready = 1'b0;
      nsent = 0; nacc = 0;
      set_lane(0, bp_a[0], 32'd1, 5'd10, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step();
         if (obs_ready[0]) begin
            nacc++; nsent++;
            if (nsent < 6) set_lane(0, bp_a[nsent], 32'(nsent + 1), AW'(10 + nsent), 1'b1, 1'b1);
            else req_valid[0] = 1'b0;
         end
      end
      check("bp_accepted", nacc, 2);
      check("bp_ready_low", obs_ready, 0);
      wb_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (obs_ready[0]) begin
            nsent++;
            if (nsent < 6) set_lane(0, bp_a[nsent], 32'(nsent + 1), AW'(10 + nsent), 1'b1, 1'b1);
            else req_valid[0] = 1'b0;
         end
      end
      check("bp_sent", nsent, 6);
      check("bp_delivered", delivered - base, 6);

      // Reset with both stages full
      wb_ready = 1'b0;
      set_lane(0, 32'h1234_5678, 32'd3, 5'd1, 1'b0, 1'b1);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_wb_valid", wb_valid, 0);
      check("mid_rst_wb_we", wb_we, 0);
      check("mid_rst_wb_data", wb_data, 0);
      check("mid_rst_wb_dest", wb_dest, 0);
      check("mid_rst_wb_tag", wb_tag, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_ready", req_ready, 0);
      q.delete();
      ptr = 0;
      req_valid = '0;
      set_lane(1, 32'h0000_0001, 32'd31, 5'd2, 1'b1, 1'b1);
      set_lane(2, 32'h8000_0000, 32'd31, 5'd4, 1'b0, 1'b1);
      wb_ready = 1'b1;
      #2 rst_n = 1'b1;
      step();
      check("post_rst_grant", obs_ready, 4'b0010);
      req_valid = '0;
      repeat (3) step();

      // Random traffic with random write-port stalls
      for (int c = 0; c < 400; c++) begin
         wb_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !obs_ready[i]) begin
               if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               set_lane(i, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                        AW'($urandom), 1'($urandom), 1'($urandom));
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         step();
      end
      req_valid = '0;
      wb_ready  = 1'b1;
      repeat (4) step();
      check("drain_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
